// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-limited sharing of the async FIFO write port
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    parameter int SRC_W      = $clog2(NUM_REQ)
) (
    input  logic                          Wclk,
    input  logic                          rstb,
    input  logic [NUM_REQ-1:0]            ReqValid,
    input  logic [NUM_REQ-1:0]            ReqLast,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqData,
    output logic [NUM_REQ-1:0]            ReqReady,
    input  logic                          Full,
    output logic                          Wen,
    output logic [DATA_WIDTH-1:0]         WrData,
    output logic [SRC_W-1:0]              WrSrc,
    output logic [SRC_W-1:0]              Owner,
    output logic                          Busy
);
    localparam int BW = $clog2(MAX_BURST + 1);
    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nx;
    logic [SRC_W-1:0] owner_nx, pick, idx;
    logic [BW-1:0] beat, beat_nx;
    logic any_valid, burst_end;
    // descending scan so the nearest requester after Owner wins; Owner itself is last
    always_comb begin
        pick = Owner;
        idx = '0;
        any_valid = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = SRC_W'((int'(Owner) + k) % NUM_REQ);
            if (ReqValid[idx]) begin
                pick = idx;
                any_valid = 1'b1;
            end
        end
    end
    assign Busy      = state == BURST;
    assign Wen       = Busy & ReqValid[Owner] & ~Full;
    assign ReqReady  = (Busy & ~Full) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << Owner : '0;
    assign WrData    = ReqData[Owner*DATA_WIDTH +: DATA_WIDTH];
    assign WrSrc     = Owner;
    assign burst_end = ReqLast[Owner] | (beat + BW'(1) == BW'(MAX_BURST));
    always_comb begin
        state_nx = state;
        owner_nx = Owner;
        beat_nx  = beat;
        if (state == IDLE) begin
            if (any_valid) begin
                state_nx = BURST;
                owner_nx = pick;
                beat_nx  = '0;
            end
        end else if (!Full) begin
            if (!ReqValid[Owner]) state_nx = IDLE;
            else begin
                beat_nx  = beat + BW'(1);
                state_nx = burst_end ? IDLE : BURST;
            end
        end
    end
    always_ff @(posedge Wclk or negedge rstb) begin
        if (!rstb) begin
            state <= IDLE;
            Owner <= SRC_W'(NUM_REQ - 1);
            beat  <= '0;
        end else begin
            state <= state_nx;
            Owner <= owner_nx;
            beat  <= beat_nx;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios checked every cycle against a behavioural arbiter model
module tb_fifo_wr_arbiter;
    localparam int N = 4, DW = 32, MB = 4;
    logic Wclk = 1'b0, rstb = 1'b0, Full = 1'b0;
    logic [N-1:0] ReqValid = '0, ReqLast = '0, ReqReady;
    logic [N*DW-1:0] ReqData = '0;
    logic Wen, Busy;
    logic [DW-1:0] WrData;
    logic [1:0] WrSrc, Owner;
    always #5 Wclk = ~Wclk;
    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .Wclk(Wclk), .rstb(rstb), .ReqValid(ReqValid), .ReqLast(ReqLast), .ReqData(ReqData),
        .ReqReady(ReqReady), .Full(Full), .Wen(Wen), .WrData(WrData), .WrSrc(WrSrc),
        .Owner(Owner), .Busy(Busy)
    );
    int total = 0, bad = 0;
    logic [DW-1:0] mem[N][16];
    bit lst[N][16];
    int head[N], tail[N], en_from[N];
    int cyc, fs, fl;
    bit m_busy;
    int m_owner, m_beat;
    int nwl;
    logic [DW-1:0] wl_data[64];
    int wl_src[64], wl_cyc[64];
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic push(input int i, input logic [DW-1:0] d, input bit l);
        mem[i][tail[i]] = d;
        lst[i][tail[i]] = l;
        tail[i]++;
    endtask
    function automatic bit pending();
        for (int i = 0; i < N; i++) if (head[i] < tail[i]) return 1'b1;
        return 1'b0;
    endfunction
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            ReqValid[i] = head[i] < tail[i] && cyc >= en_from[i];
            ReqData[i*DW +: DW] = head[i] < tail[i] ? mem[i][head[i]] : '0;
            ReqLast[i] = head[i] < tail[i] && lst[i][head[i]];
        end
        Full = cyc >= fs && cyc < fs + fl;
    endtask
    task automatic compare();
        logic [N-1:0] er;
        er = (m_busy && !Full) ? N'(1) << m_owner : '0;
        check("Busy", Busy, m_busy);
        check("ReqReady", ReqReady, er);
        check("Wen", Wen, m_busy && ReqValid[m_owner] && !Full);
        check("Owner", Owner, m_owner);
        check("WrSrc", WrSrc, m_owner);
        check("WrData", WrData, ReqData[m_owner*DW +: DW]);
    endtask
    // model: grant the nearest valid requester after the previous owner, then accept up to MB words
    task automatic update();
        if (!m_busy) begin
            for (int k = 1; k <= N; k++)
                if (ReqValid[(m_owner + k) % N]) begin
                    m_owner = (m_owner + k) % N;
                    m_beat = 0;
                    m_busy = 1'b1;
                    break;
                end
        end else if (!Full) begin
            if (!ReqValid[m_owner]) m_busy = 1'b0;
            else begin
                wl_data[nwl] = mem[m_owner][head[m_owner]];
                wl_src[nwl] = m_owner;
                wl_cyc[nwl] = cyc;
                nwl++;
                m_busy = !(lst[m_owner][head[m_owner]] || m_beat + 1 == MB);
                m_beat++;
                head[m_owner]++;
            end
        end
    endtask
    task automatic step();
        @(negedge Wclk);
        drive();
        #1 compare();
        @(posedge Wclk);
        if (rstb) update();
        cyc++;
    endtask
    task automatic run(input int lim);
        int n;
        n = 0;
        while ((m_busy || pending()) && n < lim) begin
            step();
            n++;
        end
        if (n >= lim) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d cycles required under %0d", n, lim);
        end else step();
    endtask
    task automatic model_reset();
        m_busy = 1'b0;
        m_owner = N - 1;
        m_beat = 0;
    endtask
    task automatic do_reset();
        rstb = 1'b0;
        model_reset();
        cyc = 0;
        nwl = 0;
        fs = 0;
        fl = 0;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            en_from[i] = 0;
        end
        @(negedge Wclk);
        drive();
        #1 compare();
        @(negedge Wclk);
        rstb = 1'b1;
    endtask
    task automatic check_log(input string name, input int cnt, input int srcs[], input int dats[], input int offs[]);
        check({name, "_count"}, nwl, cnt);
        for (int k = 0; k < cnt && k < nwl; k++) begin
            check({name, "_src"}, wl_src[k], srcs[k]);
            check({name, "_data"}, wl_data[k], dats[k]);
            check({name, "_cycle"}, wl_cyc[k], offs[k]);
        end
    endtask
    initial begin
        int s1[] = '{0,0,0,0,0,0,0,0,0,0};
        int d1[] = '{'h100,'h101,'h102,'h103,'h104,'h105,'h106,'h107,'h108,'h109};
        int c1[] = '{1,2,3,4,6,7,8,9,11,12};
        int s3[] = '{2,2,3,3,3,3};
        int d3[] = '{'h300,'h301,'h310,'h311,'h312,'h313};
        int c3[] = '{1,2,4,5,6,7};
        int s4[] = '{0,0,0,0};
        int d4[] = '{'h400,'h401,'h402,'h403};
        int c4[] = '{1,2,8,9};
        int s5[] = '{1,2,0};
        int d5[] = '{'h500,'h520,'h5a0};
        int c5[] = '{1,4,7};
        int s2[32], d2[32], c2[32];
        do_reset();
        check("rst_owner", Owner, 3);
        check("rst_busy", Busy, 0);
        check("rst_wen", Wen, 0);
        check("rst_ready", ReqReady, 0);
        for (int k = 0; k < 10; k++) push(0, 32'h100 + k, 1'b0);
        run(60);
        check_log("single", 10, s1, d1, c1);
        do_reset();
        for (int i = 0; i < N; i++) for (int k = 0; k < 8; k++) push(i, 32'h200 + i*16 + k, 1'b0);
        for (int k = 0; k < 32; k++) begin
            s2[k] = (k / 4) % 4;
            d2[k] = 'h200 + s2[k]*16 + (k / 16)*4 + k % 4;
            c2[k] = (k / 4)*5 + k % 4 + 1;
        end
        run(150);
        check_log("allvalid", 32, s2, d2, c2);
        do_reset();
        push(2, 32'h300, 1'b0);
        push(2, 32'h301, 1'b1);
        for (int k = 0; k < 4; k++) push(3, 32'h310 + k, 1'b0);
        run(40);
        check_log("early_last", 6, s3, d3, c3);
        do_reset();
        for (int k = 0; k < 4; k++) push(0, 32'h400 + k, 1'b0);
        fs = 3;
        fl = 5;
        run(40);
        check_log("full", 4, s4, d4, c4);
        do_reset();
        push(1, 32'h500, 1'b0);
        push(0, 32'h5a0, 1'b0);
        push(2, 32'h520, 1'b0);
        en_from[0] = 2;
        en_from[2] = 2;
        run(40);
        check_log("drop", 3, s5, d5, c5);
        do_reset();
        for (int k = 0; k < 4; k++) push(0, 32'h600 + k, 1'b0);
        step();
        step();
        @(negedge Wclk);
        drive();
        #1 compare();
        rstb = 1'b0;
        model_reset();
        #1;
        check("midrst_wen", Wen, 0);
        check("midrst_ready", ReqReady, 0);
        check("midrst_busy", Busy, 0);
        check("midrst_owner", Owner, 3);
        @(posedge Wclk);
        cyc++;
        @(negedge Wclk);
        rstb = 1'b1;
        drive();
        #1 compare();
        @(posedge Wclk);
        update();
        cyc++;
        run(40);
        check("midrst_count", nwl, 4);
        check("midrst_first", wl_data[0], 32'h600);
        check("midrst_resume_src", wl_src[1], 0);
        check("midrst_resume_data", wl_data[1], 32'h601);
        check("midrst_last_data", wl_data[3], 32'h603);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter that shares the single write port of the asynchronous FIFO (Wen/WrData/Full) among NUM_REQ requesters in the write clock domain. Grants are round-robin with a bounded burst length, so one requester cannot starve the others. Every accepted word is tagged with its source index for the read side. The block sits directly in front of the FIFO write port and is clocked by Wclk.

## Interface
- NUM_REQ, 4: number of requesters, at least 2.
- DATA_WIDTH, 32: data word width; must match the FIFO.
- MAX_BURST, 4: maximum words accepted per grant, at least 1.
- SRC_W, $clog2(NUM_REQ): width of the source tag.

Ports:
- Wclk  in  1  write-domain clock; all state changes on its rising edge.
- rstb  in  1  reset, asynchronous, active-low; clock Wclk.
- ReqValid  in  NUM_REQ  per-requester valid.
- ReqLast  in  NUM_REQ  per-requester end-of-burst marker; sampled only on a transfer.
- ReqData  in  NUM_REQ*DATA_WIDTH  packed data; requester i owns bits [i*DATA_WIDTH +: DATA_WIDTH].
- ReqReady  out  NUM_REQ  per-requester ready; one-hot or zero.
- Full  in  1  FIFO full flag, already in the Wclk domain.
- Wen  out  1  FIFO write enable.
- WrData  out  DATA_WIDTH  FIFO write data.
- WrSrc  out  SRC_W  index of the requester whose word is on WrData.
- Owner  out  SRC_W  current or last granted requester.
- Busy  out  1  high while in BURST.

## Operation
- **Transfer rule.** A transfer on requester i occurs in any cycle where ReqValid[i] and ReqReady[i] are both high.
- **States.**
  - IDLE: no grant.
  - BURST: Owner holds the port; Beat counter width is $clog2(MAX_BURST+1).
- **IDLE.**
  - If any ReqValid bit is high, select the first set bit searching upward from Owner+1, wrapping modulo NUM_REQ.
  - Load Owner with that index, clear Beat, and go to BURST.
  - ReqReady is 0 and Wen is 0 in IDLE.
- **BURST, combinational outputs.**
  - ReqReady[Owner] = ~Full; all other ReqReady bits are 0.
  - Wen = ReqValid[Owner] & ~Full.
  - WrData = ReqData slice for Owner.
  - WrSrc = Owner.
- **BURST, on a transfer.** Beat increments. Return to IDLE when any of these holds:
  - ReqLast[Owner] is 1.
  - Beat+1 equals MAX_BURST.
- **BURST, owner drops valid.** If ReqValid[Owner] is 0, no transfer occurs, the burst ends and the block returns to IDLE. Beat is not incremented.
- **Full high in BURST.** No transfer, no Beat change, state is held, and there is no timeout. Full has priority over ReqValid.
- **Fairness.** Owner keeps its value in IDLE, so the next arbitration starts after the previous owner. A requester that asserts ReqValid continuously is granted within NUM_REQ-1 other bursts.
- **Reset.** Asynchronous and takes effect mid-burst; a partially accepted burst is abandoned with no further writes. Reset values:
  - State = IDLE, Beat = 0.
  - Owner = NUM_REQ-1, so requester 0 wins the first arbitration.
  - ReqReady = 0, Wen = 0, Busy = 0.
  - WrData and WrSrc follow the mux, with Owner = NUM_REQ-1.
- **Data ownership.** The block never drops or duplicates data. Each Wen pulse corresponds to exactly one requester transfer.

## Timing
- **Arbitration latency.** ReqValid rising while in IDLE gives ReqReady/Wen on the next cycle (1-cycle bubble).
- **Throughput.** Peak throughput is MAX_BURST words per MAX_BURST+1 cycles, and one idle cycle always separates consecutive bursts.
- **Full path.** Full reaches Wen and ReqReady combinationally, in the same cycle.
- **Burst end.** The transition to IDLE happens on the clock edge that completes the last transfer. Busy falls in the following cycle.
- **Simultaneous events.**
  - ReqLast together with Beat+1 = MAX_BURST: a single burst end.
  - Full together with ReqLast: no transfer, so ReqLast is ignored that cycle.
- **Input stability.** ReqData and ReqLast must be stable while ReqValid is high and ReqReady is low. Requesters may deassert ReqValid at any time.

## Test plan
- **Single requester.** Reset, then req0 streams 10 words 0x100..0x109 with Full=0 and ReqLast=0.
  - Required: bursts of 4, 4 and 2 words, each separated by one idle cycle.
  - FIFO receives 0x100..0x109 in order with WrSrc=0.
- **All requesters valid.** All four requesters hold ReqValid high continuously.
  - Required grant order is 0,1,2,3,0,..., each burst exactly 4 words.
  - No requester waits more than 3 bursts.
- **Early ReqLast.** req2 asserts ReqLast on its 2nd word while req3 is valid.
  - Required: req2's burst ends after 2 words.
  - After one idle cycle, req3 is granted.
- **Full mid-burst.** Full is high for 5 cycles starting at the 3rd beat.
  - Required: Wen=0 and ReqReady=0 for exactly those 5 cycles, with Beat held.
  - The burst completes with the 4th word after Full falls.
- **Owner drops valid.** req1 deasserts ReqValid after 1 word of its grant.
  - Required: return to IDLE with no Wen.
  - The next arbitration starts from req2.
- **Reset mid-burst.** rstb pulses low during req0's 2nd beat.
  - Required: Wen, ReqReady and Busy drop immediately.
  - After release, the first grant goes to req0.
